instr_mem_fetch: RTL

Parametrised, synchronous instruction memory with a valid/ready fetch port, a configurable read pipeline of 1 or 2 cycles, and a program-load write port. It replaces the combinational word-addressed instruction ROM in the fetch path, so the CPU can move toward multi-cycle and pipelined cores. Out-of-range and misaligned fetches return a NOP and raise per-response fault flags. A completed-fetch counter supports performance checks.

---
 rtl/instr_mem_fetch.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/instr_mem_fetch.sv
// rtl/instr_mem_fetch.sv - synchronous instruction memory with valid/ready fetch port
//
// Purpose:
//   Word-organised instruction memory read through a 1- or 2-stage pipeline.
//   Fetches carry a byte address; misaligned or out-of-range fetches return
//   DEFAULT_INSTR and report fault flags. A program-load port writes words
//   independently of the fetch pipeline. fetch_count counts response handshakes.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   req_valid/ready/addr  fetch request (byte address)
//   rsp_valid/ready       fetch response handshake
//   rsp_data              fetched word or DEFAULT_INSTR on fault
//   rsp_addr              byte address echoed from the request
//   rsp_fault             bit0 misaligned, bit1 out of range
//   prog_en/addr/data     program-load write port (word index)
//   fetch_count           completed response handshakes, wraps

module instr_mem_fetch #(
  parameter int                 DATA_W        = 32,
  parameter int                 ADDR_W        = 32,
  parameter int                 DEPTH         = 256,
  parameter int                 LATENCY       = 1,
  parameter logic [DATA_W-1:0]  DEFAULT_INSTR = 'h00000013,
  parameter string              INIT_FILE     = ""
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [ADDR_W-1:0]          req_addr,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_data,
  output logic [ADDR_W-1:0]          rsp_addr,
  output logic [1:0]                 rsp_fault,
  input  logic                       prog_en,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [DATA_W-1:0]          prog_data,
  output logic [31:0]                fetch_count
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Stage 1: captures the request and holds the registered memory read
  logic              r_s1_valid;
  logic [ADDR_W-1:0] r_s1_addr;
  logic [1:0]        r_s1_fault;
  logic [DATA_W-1:0] r_s1_data;

  // Last stage view (stage 1 or stage 2 depending on LATENCY)
  logic              w_last_valid;
  logic [ADDR_W-1:0] w_last_addr;
  logic [1:0]        w_last_fault;
  logic [DATA_W-1:0] w_last_data;

  logic              w_stall;
  logic              w_accept;
  logic              w_misaligned;
  logic              w_out_of_range;
  logic [1:0]        w_fault;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_data;
  logic [31:0]       r_fetch_count;

  // DEPTH is a power of two, so any set bit above the word index is out of range
  assign w_misaligned   = |req_addr[1:0];
  assign w_out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
  assign w_fault        = {w_out_of_range, w_misaligned};
  assign w_idx          = req_addr[IDX_W+1:2];

  assign w_stall   = w_last_valid & ~rsp_ready;
  assign req_ready = ~w_stall;
  assign w_accept  = req_valid & req_ready;

  // Faulting fetches never index the array
  always_comb begin
    w_rd_data = DEFAULT_INSTR;
    if (w_fault == 2'b00) begin
      w_rd_data = r_mem[w_idx];
    end
  end

  // Program port is not reset and ignores stall; the stage-1 read of the
  // same edge sees the old word (read-first).
  always_ff @(posedge clk) begin
    if (prog_en) begin
      r_mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_addr  <= '0;
      r_s1_fault <= 2'b00;
      r_s1_data  <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      r_s1_addr  <= req_addr;
      r_s1_fault <= w_fault;
      r_s1_data  <= w_rd_data;
    end
  end

  generate
    if (LATENCY == 2) begin : g_lat2
      logic              r_s2_valid;
      logic [ADDR_W-1:0] r_s2_addr;
      logic [1:0]        r_s2_fault;
      logic [DATA_W-1:0] r_s2_data;

      always_ff @(posedge clk) begin
        if (rst) begin
          r_s2_valid <= 1'b0;
          r_s2_addr  <= '0;
          r_s2_fault <= 2'b00;
          r_s2_data  <= '0;
        end else if (!w_stall) begin
          r_s2_valid <= r_s1_valid;
          r_s2_addr  <= r_s1_addr;
          r_s2_fault <= r_s1_fault;
          r_s2_data  <= r_s1_data;
        end
      end

      assign w_last_valid = r_s2_valid;
      assign w_last_addr  = r_s2_addr;
      assign w_last_fault = r_s2_fault;
      assign w_last_data  = r_s2_data;
    end else begin : g_lat1
      assign w_last_valid = r_s1_valid;
      assign w_last_addr  = r_s1_addr;
      assign w_last_fault = r_s1_fault;
      assign w_last_data  = r_s1_data;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= '0;
    end else if (w_last_valid && rsp_ready) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign rsp_valid   = w_last_valid;
  assign rsp_addr    = w_last_addr;
  assign rsp_fault   = w_last_fault;
  assign rsp_data    = w_last_data;
  assign fetch_count = r_fetch_count;

endmodule
